// File: rtl/access_session_ctrl.sv
// Login/logout session controller fed by the 3-bit profile decoder.
// It handles the inactivity timeout, lockout after repeated bad logins, and the per-profile enables.
module access_session_ctrl #(
    parameter int MAX_FAILS   = 3,
    parameter int TIMEOUT     = 16,
    parameter int LOCK_CYCLES = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [2:0]                       perfil,
    input  logic                             login,
    input  logic                             logout,
    input  logic                             activity,
    output logic                             session_active,
    output logic [2:0]                       cur_profile,
    output logic                             granted,
    output logic                             denied,
    output logic                             timeout,
    output logic                             locked,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
    output logic                             admin_en,
    output logic                             tester_en,
    output logic                             user_en,
    output logic                             guest_en
);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int IW = $clog2(TIMEOUT);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SESSION = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    localparam logic [2:0] P_ADMIN  = 3'b101;
    localparam logic [2:0] P_TESTER = 3'b110;
    localparam logic [2:0] P_USER   = 3'b100;
    localparam logic [2:0] P_GUEST  = 3'b011;

    logic [1:0]    state_q,   state_d;
    logic [2:0]    profile_q, profile_d;
    logic [FW-1:0] fail_q,    fail_d;
    logic [IW-1:0] idle_q,    idle_d;
    logic [LW-1:0] lock_q,    lock_d;
    logic          granted_q, granted_d;
    logic          denied_q,  denied_d;
    logic          timeout_q, timeout_d;

    logic          perfil_valid;
    logic [FW-1:0] fail_inc;

    always_comb begin
        perfil_valid = 1'b0;
        case (perfil)
            P_ADMIN, P_TESTER, P_USER, P_GUEST: perfil_valid = 1'b1;
            default:                            perfil_valid = 1'b0;
        endcase
    end

    assign fail_inc = fail_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        profile_d = profile_q;
        fail_d    = fail_q;
        idle_d    = idle_q;
        lock_d    = lock_q;
        granted_d = 1'b0;
        denied_d  = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (login) begin
                    if (perfil_valid) begin
                        state_d   = S_SESSION;
                        profile_d = perfil;
                        granted_d = 1'b1;
                        fail_d    = '0;
                        idle_d    = '0;
                    end else begin
                        denied_d = 1'b1;
                        fail_d   = fail_inc;
                        // Lockout leaves fail_count parked at MAX_FAILS until the lock expires.
                        if (fail_inc == FW'(MAX_FAILS)) begin
                            state_d = S_LOCKED;
                            lock_d  = '0;
                        end
                    end
                end
            end
            S_SESSION: begin
                if (logout) begin
                    state_d   = S_IDLE;
                    profile_d = 3'b000;
                    idle_d    = '0;
                end else if (activity) begin
                    idle_d = '0;
                end else if (idle_q == IW'(TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    profile_d = 3'b000;
                    idle_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            S_LOCKED: begin
                denied_d = login;
                if (lock_q == LW'(LOCK_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    fail_d  = '0;
                    lock_d  = '0;
                end else begin
                    lock_d = lock_q + 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                profile_d = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            profile_q <= 3'b000;
            fail_q    <= '0;
            idle_q    <= '0;
            lock_q    <= '0;
            granted_q <= 1'b0;
            denied_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            profile_q <= profile_d;
            fail_q    <= fail_d;
            idle_q    <= idle_d;
            lock_q    <= lock_d;
            granted_q <= granted_d;
            denied_q  <= denied_d;
            timeout_q <= timeout_d;
        end
    end

    assign session_active = (state_q == S_SESSION);
    assign locked         = (state_q == S_LOCKED);
    assign cur_profile    = profile_q;
    assign fail_count     = fail_q;
    assign granted        = granted_q;
    assign denied         = denied_q;
    assign timeout        = timeout_q;

    // The profile register clears on every exit from SESSION, so these enables stay mutually exclusive.
    assign admin_en  = session_active && (profile_q == P_ADMIN);
    assign tester_en = session_active && (profile_q == P_TESTER);
    assign user_en   = session_active && (profile_q == P_USER);
    assign guest_en  = session_active && (profile_q == P_GUEST);
endmodule

// File: tb/tb_access_session_ctrl.sv
// Directed testbench for access_session_ctrl with hand-computed expectations.
// Inputs change 1 time unit after each rising edge, and outputs are sampled at the same point.
module tb_access_session_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] perfil;
    logic       login, logout, activity;
    logic       session_active, granted, denied, timeout, locked;
    logic [2:0] cur_profile;
    logic [1:0] fail_count;
    logic       admin_en, tester_en, user_en, guest_en;

    int n_cmp = 0;
    int n_bad = 0;

    access_session_ctrl #(.MAX_FAILS(3), .TIMEOUT(16), .LOCK_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .perfil(perfil), .login(login), .logout(logout),
        .activity(activity), .session_active(session_active), .cur_profile(cur_profile),
        .granted(granted), .denied(denied), .timeout(timeout), .locked(locked),
        .fail_count(fail_count), .admin_en(admin_en), .tester_en(tester_en),
        .user_en(user_en), .guest_en(guest_en)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] ens();
        return {admin_en, tester_en, user_en, guest_en};
    endfunction

    initial begin
        logic seen_to;
        rst = 1'b1; perfil = 3'b000; login = 1'b0; logout = 1'b0; activity = 1'b0;
        #2;
        check("rst_session", session_active, 0);
        check("rst_profile", cur_profile, 0);
        check("rst_fail", fail_count, 0);
        check("rst_locked", locked, 0);
        check("rst_pulses", {granted, denied, timeout}, 0);
        check("rst_en", ens(), 0);
        rst = 1'b0;
        tick();

        // Admin login, then logout
        perfil = 3'b101; login = 1'b1;
        tick(); login = 1'b0;
        check("adm_granted", granted, 1);
        check("adm_session", session_active, 1);
        check("adm_profile", cur_profile, 3'b101);
        check("adm_en", ens(), 4'b1000);
        tick();
        check("adm_granted_end", granted, 0);
        logout = 1'b1;
        tick(); logout = 1'b0;
        check("lo_session", session_active, 0);
        check("lo_profile", cur_profile, 0);
        check("lo_en", ens(), 0);
        check("lo_no_timeout", timeout, 0);

        // Three invalid logins lead to lockout
        perfil = 3'b000;
        for (int i = 1; i <= 3; i++) begin
            login = 1'b1;
            tick(); login = 1'b0;
            check("bad_denied", denied, 1);
            check("bad_fail", fail_count, i);
            check("bad_locked", locked, (i == 3) ? 1 : 0);
            tick();
            check("bad_denied_end", denied, 0);
        end
        login = 1'b1;
        tick(); login = 1'b0;
        check("lock_denied", denied, 1);
        check("lock_fail", fail_count, 3);
        check("lock_locked", locked, 1);
        repeat (29) tick();
        check("lock_last_cycle", locked, 1);
        tick();
        check("lock_exit", locked, 0);
        check("lock_exit_fail", fail_count, 0);

        // Fail count clears on a valid login
        perfil = 3'b000; login = 1'b1;
        tick();
        check("clr_fail1", fail_count, 1);
        tick();
        check("clr_fail2", fail_count, 2);
        check("clr_denied2", denied, 1);
        perfil = 3'b011;
        tick(); login = 1'b0;
        check("clr_granted", granted, 1);
        check("clr_denied", denied, 0);
        check("clr_fail0", fail_count, 0);
        check("clr_profile", cur_profile, 3'b011);
        check("clr_en", ens(), 4'b0001);
        logout = 1'b1;
        tick(); logout = 1'b0;

        // Inactivity timeout
        perfil = 3'b110; login = 1'b1;
        tick(); login = 1'b0;
        check("to_en", ens(), 4'b0100);
        repeat (15) tick();
        check("to_pre_session", session_active, 1);
        check("to_pre_pulse", timeout, 0);
        tick();
        check("to_pulse", timeout, 1);
        check("to_session", session_active, 0);
        check("to_en_off", ens(), 0);
        check("to_profile", cur_profile, 0);
        tick();
        check("to_pulse_end", timeout, 0);

        // Activity restarts the idle timer
        login = 1'b1;
        tick(); login = 1'b0;
        repeat (9) tick();
        activity = 1'b1;
        tick(); activity = 1'b0;
        repeat (15) tick();
        check("act_pre_pulse", timeout, 0);
        check("act_pre_session", session_active, 1);
        tick();
        check("act_pulse", timeout, 1);
        check("act_session", session_active, 0);

        // Logout takes priority over activity
        tick();
        login = 1'b1;
        tick(); login = 1'b0;
        repeat (3) tick();
        logout = 1'b1; activity = 1'b1;
        tick(); logout = 1'b0; activity = 1'b0;
        check("pri_session", session_active, 0);
        seen_to = timeout;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen_to = seen_to | timeout;
        end
        check("pri_no_timeout", seen_to, 0);

        // Login while in SESSION is ignored
        perfil = 3'b101; login = 1'b1;
        tick();
        perfil = 3'b110;
        tick(); login = 1'b0;
        check("relog_granted", granted, 0);
        check("relog_denied", denied, 0);
        check("relog_profile", cur_profile, 3'b101);
        logout = 1'b1;
        tick(); logout = 1'b0;

        // Reset in the middle of a session
        perfil = 3'b100; login = 1'b1;
        tick(); login = 1'b0;
        check("mid_en", ens(), 4'b0010);
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        check("mid_session", session_active, 0);
        check("mid_en_off", ens(), 0);
        check("mid_profile", cur_profile, 0);
        check("mid_pulses", {granted, denied, timeout}, 0);
        tick();
        rst = 1'b0;
        tick();
        check("mid_after_session", session_active, 0);
        check("mid_after_pulses", {granted, denied, timeout}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
